// File: rtl/mic_volume_meter_if.sv
// Sample-in / level-out bundle between the microphone front end and the meter.
// Latency and backpressure: none here, because this file only holds wires. The sample side is strobed and cannot stall.
interface mic_volume_meter_if;
    logic        sample_tick;
    logic [11:0] mic_in;
    logic        freeze;
    logic [4:0]  volume_signal;
    logic        volume_valid;
    logic        peak_clip;

    modport master (
        output sample_tick, mic_in, freeze,
        input  volume_signal, volume_valid, peak_clip
    );

    modport slave (
        input  sample_tick, mic_in, freeze,
        output volume_signal, volume_valid, peak_clip
    );
endinterface

// File: rtl/mic_volume_meter.sv
// Peak-over-window volume meter: 12-bit mic samples in, 0..16 level out once per window.
// Latency: the level publishes 2 cycles after the final tick of a window. There is no backpressure, and every tick is consumed.
module mic_volume_meter #(
    parameter int WINDOW_SAMPLES = 4000,
    parameter int BASELINE       = 2048,
    parameter int DECAY_EN       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mic_volume_meter_if.slave  bus
);
    localparam logic [11:0] BASE     = BASELINE[11:0];
    localparam logic [15:0] WIN_LAST = 16'(WINDOW_SAMPLES - 1);
    localparam logic [11:0] FULL_EXC = 12'd2047;
    localparam bit          DECAY    = (DECAY_EN != 0);

    typedef enum logic {ACCUM, PUBLISH} state_t;

    state_t      state_q, state_d;
    logic [11:0] peak_q, peak_d;
    logic        clip_acc_q, clip_acc_d;
    logic [15:0] count_q, count_d;
    logic [4:0]  vol_q, vol_d;
    logic        vld_q, vld_d;
    logic        clip_q, clip_d;

    logic [11:0] excess;
    logic        full_scale;
    logic [4:0]  raw_level;
    logic [4:0]  new_level;

    always_comb begin
        excess     = (bus.mic_in > BASE) ? (bus.mic_in - BASE) : 12'd0;
        full_scale = (bus.mic_in == 12'hFFF);
        // Saturate at full-scale excess so a low BASELINE cannot alias back into 0..15.
        raw_level  = (peak_q >= FULL_EXC) ? 5'd16 : {1'b0, peak_q[10:7]};
        new_level  = (DECAY && (raw_level < vol_q)) ? (vol_q - 5'd1) : raw_level;
    end

    always_comb begin
        state_d    = state_q;
        peak_d     = peak_q;
        clip_acc_d = clip_acc_q;
        count_d    = count_q;
        vol_d      = vol_q;
        vld_d      = 1'b0;
        clip_d     = clip_q;
        case (state_q)
            ACCUM: begin
                if (bus.sample_tick) begin
                    peak_d     = (excess > peak_q) ? excess : peak_q;
                    clip_acc_d = clip_acc_q | full_scale;
                    if (count_q == WIN_LAST) begin
                        state_d = PUBLISH;
                    end else begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            PUBLISH: begin
                if (!bus.freeze) begin
                    vol_d = new_level;
                    vld_d = 1'b1;
                end
                clip_d  = clip_acc_q;
                state_d = ACCUM;
                // A tick here opens the next window rather than being lost.
                if (bus.sample_tick) begin
                    peak_d     = excess;
                    clip_acc_d = full_scale;
                    count_d    = 16'd1;
                end else begin
                    peak_d     = 12'd0;
                    clip_acc_d = 1'b0;
                    count_d    = 16'd0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            peak_q     <= 12'd0;
            clip_acc_q <= 1'b0;
            count_q    <= 16'd0;
            vol_q      <= 5'd0;
            vld_q      <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            peak_q     <= peak_d;
            clip_acc_q <= clip_acc_d;
            count_q    <= count_d;
            vol_q      <= vol_d;
            vld_q      <= vld_d;
            clip_q     <= clip_d;
        end
    end

    assign bus.volume_signal = vol_q;
    assign bus.volume_valid  = vld_q;
    assign bus.peak_clip     = clip_q;
endmodule

// File: tb/tb_mic_volume_meter.sv
// Scoreboard bench: two meters (decay off / on, 8-sample windows) share one stimulus stream.
module tb_mic_volume_meter;
    typedef struct {
        logic [4:0] vol;
        logic       clip;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [11:0] mic = 12'd0;
    logic        frz = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_tick_cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   pc0[$];
    int   pc1[$];

    mic_volume_meter_if if0 ();
    mic_volume_meter_if if1 ();

    assign if0.sample_tick = tick;
    assign if0.mic_in      = mic;
    assign if0.freeze      = frz;
    assign if1.sample_tick = tick;
    assign if1.mic_in      = mic;
    assign if1.freeze      = frz;

    mic_volume_meter #(.WINDOW_SAMPLES(8), .BASELINE(2048), .DECAY_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    mic_volume_meter #(.WINDOW_SAMPLES(8), .BASELINE(2048), .DECAY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if0.volume_valid) begin
            pc0.push_back(cyc);
            if (q0.size() == 0) begin
                cmp("unexpected_pulse_dut0", 1, 0);
            end else begin
                e = q0.pop_front();
                cmp("vol_dut0", int'(if0.volume_signal), int'(e.vol));
                cmp("clip_dut0", int'(if0.peak_clip), int'(e.clip));
            end
        end
        if (rst_n && if1.volume_valid) begin
            pc1.push_back(cyc);
            if (q1.size() == 0) begin
                cmp("unexpected_pulse_dut1", 1, 0);
            end else begin
                e = q1.pop_front();
                cmp("vol_dut1", int'(if1.volume_signal), int'(e.vol));
                cmp("clip_dut1", int'(if1.peak_clip), int'(e.clip));
            end
        end
    end

    task automatic expect_win(input int v0, input int v1, input bit c);
        exp_t e;
        e.clip = c;
        e.vol  = 5'(v0);
        q0.push_back(e);
        e.vol  = 5'(v1);
        q1.push_back(e);
    endtask

    // n back-to-back ticks at val; the sample at clip_idx is forced to 4095.
    task automatic send(input logic [11:0] val, input int n, input int clip_idx);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick = 1'b1;
            mic  = (i == clip_idx) ? 12'hFFF : val;
            last_tick_cyc = cyc;
        end
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_vol0"}, int'(if0.volume_signal), 0);
        cmp({nm, "_vld0"}, int'(if0.volume_valid), 0);
        cmp({nm, "_clip0"}, int'(if0.peak_clip), 0);
        cmp({nm, "_vol1"}, int'(if1.volume_signal), 0);
        cmp({nm, "_vld1"}, int'(if1.volume_valid), 0);
        cmp({nm, "_clip1"}, int'(if1.peak_clip), 0);
    endtask

    initial begin
        int base;
        #1;
        check_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // 640 above baseline -> level 5; pulse two cycles after the last tick.
        expect_win(5, 5, 1'b0);
        send(12'd2688, 8, -1);
        idle(4);
        cmp("latency", (pc0.size() > 0) ? pc0[0] - last_tick_cyc : -1, 2);

        // One full-scale sample among excess-1000 samples.
        expect_win(16, 16, 1'b1);
        send(12'd3048, 8, 3);
        idle(4);
        expect_win(0, 15, 1'b0);
        send(12'd2048, 8, -1);
        idle(4);

        // Decay ballistics: 15 then silence, then straight back up.
        expect_win(15, 15, 1'b0);
        send(12'd3968, 8, -1);
        idle(4);
        expect_win(0, 14, 1'b0);
        send(12'd2048, 8, -1);
        idle(4);
        expect_win(0, 13, 1'b0);
        send(12'd2048, 8, -1);
        idle(4);
        expect_win(0, 12, 1'b0);
        send(12'd2048, 8, -1);
        idle(4);
        expect_win(15, 15, 1'b0);
        send(12'd3968, 8, -1);
        idle(4);

        // Continuous ticks, ramp of 64 per sample: window peaks 448, 960, 1472.
        base = pc0.size();
        expect_win(3, 14, 1'b0);
        expect_win(7, 13, 1'b0);
        expect_win(11, 12, 1'b0);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            tick = 1'b1;
            mic  = 12'(2048 + i * 64);
        end
        @(posedge clk);
        #1;
        tick = 1'b0;
        idle(4);
        cmp("burst_pulses", pc0.size() - base, 3);
        if (pc0.size() - base == 3) begin
            cmp("burst_gap1", pc0[base + 1] - pc0[base], 8);
            cmp("burst_gap2", pc0[base + 2] - pc0[base + 1], 8);
        end

        // Freeze holds the level while peak_clip still tracks each window.
        expect_win(3, 11, 1'b0);
        send(12'd2432, 8, -1);
        idle(4);
        frz = 1'b1;
        send(12'd3200, 8, -1);
        idle(4);
        cmp("frz_vol0", int'(if0.volume_signal), 3);
        cmp("frz_vol1", int'(if1.volume_signal), 11);
        cmp("frz_clip0", int'(if0.peak_clip), 0);
        send(12'd3200, 8, 5);
        idle(4);
        cmp("frz2_vol0", int'(if0.volume_signal), 3);
        cmp("frz2_vol1", int'(if1.volume_signal), 11);
        cmp("frz2_clip0", int'(if0.peak_clip), 1);
        cmp("frz2_clip1", int'(if1.peak_clip), 1);
        frz = 1'b0;
        expect_win(9, 10, 1'b0);
        send(12'd3200, 8, -1);
        idle(4);

        // Asynchronous reset mid-window discards the partial window.
        send(12'd3968, 5, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        idle(2);
        rst_n = 1'b1;
        expect_win(2, 2, 1'b0);
        send(12'd2304, 8, -1);
        idle(5);

        cmp("pending_dut0", q0.size(), 0);
        cmp("pending_dut1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
